dice_pool_roller: RTL and testbench
===================================

Name: dice_pool_roller

Overview:
- Parametrised successor to the single-d20 roll path.
- Resolves a roll of up to MAX_DICE dice, or a two-die advantage/disadvantage roll, from a preloaded random table.
- Adds a signed modifier with saturation, compares against a target, and flags natural crit/fumble.
- Sits between the bit-table loader (write/addr/data interface) and the game-logic front end that issues start requests.

Parameters:
- NUM_BITS, 8: signed width of mod, target, final_num.
- DIE_BITS, 5: width of one raw die value / table entry.
- DEPTH, 32: random-table entries; power of two.
- MAX_DICE, 4: maximum dice per normal roll.
- DIE_SIDES, 20: natural-crit value; natural fumble is fixed at 1.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low reset.
- write, in, 1: table write strobe.
- addr, in, $clog2(DEPTH): table write address.
- data, in, DIE_BITS: table write data, a pre-scaled die value 1..DIE_SIDES.
- start, in, 1: roll request.
- mode, in, 2: 0 normal, 1 advantage, 2 disadvantage, 3 treated as normal.
- num_dice, in, $clog2(MAX_DICE+1): dice count for normal mode.
- mod, in, NUM_BITS signed: modifier.
- target, in, NUM_BITS signed: hit threshold.
- busy, out, 1: roll in progress.
- done, out, 1: one-cycle result pulse.
- random_num, out, DIE_BITS: kept natural die (last die in normal multi-die mode).
- final_num, out, NUM_BITS signed: saturated sum plus mod.
- hit, out, 1: final_num >= target (signed).
- crit, out, 1: natural max on a single-die or adv/dis roll.
- fumble, out, 1: natural 1 on a single-die or adv/dis roll.
- rd_ptr, out, $clog2(DEPTH): next table entry to consume.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; rd_ptr=0; busy, done, hit, crit, fumble = 0; random_num=0; final_num=0. Table contents are not cleared. Reset mid-roll aborts with no done pulse.
- Table writes are accepted only in IDLE: table[addr] <= data at the posedge. In IDLE, write has priority over start; start is ignored that cycle.
- Writes outside IDLE are dropped.
- States and transitions:
  - IDLE: start=1 and write=0 -> latch mode, mod, target, effective count n; clear accumulator; go to ROLL.
  - Effective count n: normal mode uses num_dice, with 0 -> 1 and >MAX_DICE -> MAX_DICE. Adv/dis uses n=2.
  - ROLL: one entry per cycle. Read table[rd_ptr], advance rd_ptr with wrap DEPTH-1 -> 0.
    - Normal: sum += entry.
    - Adv/dis: keep max/min of the two entries.
    - Leave after n cycles -> RESOLVE.
  - RESOLVE: compute final_num = sat(sum_or_kept + mod) to [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1]. The sum uses a width wide enough for MAX_DICE*(2^DIE_BITS-1) plus mod without wrap.
    - Register final_num, hit, random_num, crit, fumble.
    - crit/fumble are 0 in normal mode with n>1.
    - Pulse done. Go to IDLE.
- busy=1 in ROLL and RESOLVE.
- Latency: start accepted at edge k; done=1 and results valid after edge k+n+1.
- Results hold until the next RESOLVE.
- start while busy is ignored; there is no queueing.
- A back-to-back start is accepted in the cycle after done.

Decomposition:
- Package dice_pkg:
  - roll_mode_t enum (MODE_NORMAL, MODE_ADV, MODE_DIS).
  - roller_state_t enum (IDLE, ROLL, RESOLVE).
  - FUMBLE_VAL=1.
  - Function sat_add for the saturating signed add.
- Sub-module dice_table:
  - DEPTH x DIE_BITS register array.
  - Synchronous write port, combinational read port on rd_ptr.
- The FSM, accumulator and compare stay in dice_pool_roller.

Test Plan:
- Single die, hit and latency:
  - Stimulus: load table[0..4]=7,20,1,13,4; mode=0, num_dice=1, mod=5, target=10; start.
  - Response: done 2 cycles after acceptance; random_num=7, final_num=12, hit=1, crit=0, rd_ptr=1.
- Advantage with crit:
  - Stimulus: rd_ptr=1, mode=1, mod=-3, target=18.
  - Response: entries 20 and 1 read, kept 20; final_num=17, hit=0, crit=1, fumble=0; done 3 cycles after acceptance; rd_ptr=3.
- Disadvantage with fumble:
  - Stimulus: reset, then rd_ptr=0 with table[0..1]=1,20; mode=2, mod=0, target=1.
  - Response: kept 1; final_num=1, hit=1, fumble=1.
- Pointer wrap:
  - Stimulus: advance rd_ptr to 31; table[31]=5, table[0]=6, table[1]=7; normal roll, num_dice=3, mod=0.
  - Response: final_num=18; rd_ptr=2.
- Saturation and clamping:
  - Stimulus: all entries 31; num_dice=7; mod=127.
  - Response: count clamped to 4; final_num=127.
  - Stimulus: all entries 1, num_dice=1, mod=-128, target=-128.
  - Response: final_num=-127, hit=1.
- Reset and write/start conflicts:
  - Stimulus: reset driven low during ROLL.
  - Response: next cycle busy=0, done never pulses, rd_ptr=0, table preserved.
  - Stimulus: write and start together in IDLE.
  - Response: write lands, no roll starts.
  - Stimulus: write while busy.
  - Response: table unchanged.

Source files
------------

// File: rtl/dice_pool_roller_pkg.sv
// Shared types and helpers for the dice pool roller.
package dice_pkg;

    // Roll flavours; the raw 2-bit mode code 3 maps onto MODE_NORMAL.
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_ADV    = 2'd1,
        MODE_DIS    = 2'd2
    } roll_mode_t;

    // Roller sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLL    = 2'd1,
        RESOLVE = 2'd2
    } roller_state_t;

    // A natural fumble is always a face value of one.
    localparam int FUMBLE_VAL = 1;

    // Signed add clamped to the range of an nbits-wide two's complement value.
    // Operands are carried as int so the sum can never wrap for any sensible
    // die/modifier width.
    function automatic int sat_add(input int a, input int b, input int nbits);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 << (nbits - 1)) - 1;
        lo = -(1 << (nbits - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/dice_pool_roller_if.sv
// Bus between the table loader / game front end and the dice pool roller.
//
// Handshake: start is a single-cycle request with no ready. It is taken on a
// rising edge only while the roller is idle (busy=0) and write is low; a start
// seen while busy, or together with write, is dropped without queueing.
// done pulses for exactly one cycle and the result fields are valid from that
// cycle until the next done.
interface dice_pool_roller_if #(
    parameter int NUM_BITS = 8,
    parameter int DIE_BITS = 5,
    parameter int DEPTH    = 32,
    parameter int MAX_DICE = 4
);
    import dice_pkg::*;

    // table loader
    logic                               write;
    logic [$clog2(DEPTH)-1:0]           addr;
    logic [DIE_BITS-1:0]                data;
    // roll request
    logic                               start;
    logic [1:0]                         mode;
    logic [$clog2(MAX_DICE+1)-1:0]      num_dice;
    logic signed [NUM_BITS-1:0]         mod;
    logic signed [NUM_BITS-1:0]         target;
    // roll result
    logic                               busy;
    logic                               done;
    logic [DIE_BITS-1:0]                random_num;
    logic signed [NUM_BITS-1:0]         final_num;
    logic                               hit;
    logic                               crit;
    logic                               fumble;
    logic [$clog2(DEPTH)-1:0]           rd_ptr;
    // sequencer state, exposed for observation
    roller_state_t                      dbg_state;

    modport master (
        output write, addr, data, start, mode, num_dice, mod, target,
        input  busy, done, random_num, final_num, hit, crit, fumble, rd_ptr,
               dbg_state
    );

    modport slave (
        input  write, addr, data, start, mode, num_dice, mod, target,
        output busy, done, random_num, final_num, hit, crit, fumble, rd_ptr,
               dbg_state
    );

endinterface

// File: rtl/dice_pool_roller_table.sv
// Preloaded random table: synchronous write, combinational read.
module dice_table #(
    parameter int DEPTH    = 32,
    parameter int DIE_BITS = 5
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DIE_BITS-1:0]      i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DIE_BITS-1:0]      o_rdata
);

    // Contents deliberately survive reset so a reload is not needed.
    logic [DIE_BITS-1:0] r_mem [DEPTH];

    // Store one entry per write strobe.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dice_pool_roller.sv
// Dice pool roller: sums up to MAX_DICE table entries, or keeps the best/worst
// of two for advantage/disadvantage, then applies a saturating modifier,
// compares against a target and flags natural crit/fumble.
module dice_pool_roller
    import dice_pkg::*;
#(
    parameter int NUM_BITS  = 8,
    parameter int DIE_BITS  = 5,
    parameter int DEPTH     = 32,
    parameter int MAX_DICE  = 4,
    parameter int DIE_SIDES = 20
) (
    input logic               clk,
    input logic               reset,
    dice_pool_roller_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_DICE + 1);
    // Unsigned width that holds MAX_DICE maximal entries without wrapping.
    localparam int ACC_W = $clog2(MAX_DICE * ((1 << DIE_BITS) - 1) + 1);

    roller_state_t              r_state;
    roll_mode_t                 r_mode;
    logic [CNT_W-1:0]           r_n;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [NUM_BITS-1:0] r_mod;
    logic signed [NUM_BITS-1:0] r_target;
    logic [ACC_W-1:0]           r_acc;
    logic [DIE_BITS-1:0]        r_last;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic                       r_busy;
    logic                       r_done;
    logic [DIE_BITS-1:0]        r_random;
    logic signed [NUM_BITS-1:0] r_final;
    logic                       r_hit;
    logic                       r_crit;
    logic                       r_fumble;

    logic [DIE_BITS-1:0]        w_entry;
    logic                       w_we;
    roll_mode_t                 w_req_mode;
    logic [CNT_W-1:0]           w_eff_n;
    logic [ACC_W-1:0]           w_entry_ext;
    logic [ACC_W-1:0]           w_acc_next;
    logic [DIE_BITS-1:0]        w_kept;
    logic                       w_single;
    logic signed [NUM_BITS-1:0] w_final;
    logic                       w_hit;

    // The loader may only touch the table while no roll is reading it.
    assign w_we = bus.write && (r_state == IDLE) && reset;

    dice_table #(
        .DEPTH    (DEPTH),
        .DIE_BITS (DIE_BITS)
    ) u_table (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (bus.addr),
        .i_wdata (bus.data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_entry)
    );

    // Decode the requested mode and clamp the dice count to 1..MAX_DICE.
    always_comb begin
        w_req_mode = MODE_NORMAL;
        if (bus.mode == 2'd1) begin
            w_req_mode = MODE_ADV;
        end else if (bus.mode == 2'd2) begin
            w_req_mode = MODE_DIS;
        end
        w_eff_n = bus.num_dice;
        if (w_req_mode != MODE_NORMAL) begin
            w_eff_n = CNT_W'(2);
        end else if (bus.num_dice == '0) begin
            w_eff_n = CNT_W'(1);
        end else if (bus.num_dice > CNT_W'(MAX_DICE)) begin
            w_eff_n = CNT_W'(MAX_DICE);
        end
    end

    // Fold the current table entry into the accumulator (sum, max or min).
    always_comb begin
        w_entry_ext = ACC_W'(w_entry);
        w_acc_next  = r_acc + w_entry_ext;
        if (r_mode == MODE_ADV) begin
            w_acc_next = ((r_cnt == '0) || (w_entry_ext > r_acc)) ? w_entry_ext : r_acc;
        end else if (r_mode == MODE_DIS) begin
            w_acc_next = ((r_cnt == '0) || (w_entry_ext < r_acc)) ? w_entry_ext : r_acc;
        end
    end

    // Result datapath: kept natural die, saturated total and target compare.
    always_comb begin
        w_kept   = (r_mode == MODE_NORMAL) ? r_last : r_acc[DIE_BITS-1:0];
        w_single = (r_mode != MODE_NORMAL) || (r_n == CNT_W'(1));
        w_final  = NUM_BITS'(sat_add(int'(r_acc), int'(r_mod), NUM_BITS));
        w_hit    = (w_final >= r_target);
    end

    // Roll sequencer with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_mode   <= MODE_NORMAL;
            r_n      <= '0;
            r_cnt    <= '0;
            r_mod    <= '0;
            r_target <= '0;
            r_acc    <= '0;
            r_last   <= '0;
            r_rd_ptr <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_random <= '0;
            r_final  <= '0;
            r_hit    <= 1'b0;
            r_crit   <= 1'b0;
            r_fumble <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.write) begin
                        r_mode   <= w_req_mode;
                        r_n      <= w_eff_n;
                        r_mod    <= bus.mod;
                        r_target <= bus.target;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ROLL;
                    end
                end
                ROLL: begin
                    r_acc    <= w_acc_next;
                    r_last   <= w_entry;
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == r_n - CNT_W'(1)) begin
                        r_state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    r_random <= w_kept;
                    r_final  <= w_final;
                    r_hit    <= w_hit;
                    r_crit   <= w_single && (w_kept == DIE_BITS'(DIE_SIDES));
                    r_fumble <= w_single && (w_kept == DIE_BITS'(FUMBLE_VAL));
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.random_num = r_random;
    assign bus.final_num  = r_final;
    assign bus.hit        = r_hit;
    assign bus.crit       = r_crit;
    assign bus.fumble     = r_fumble;
    assign bus.rd_ptr     = r_rd_ptr;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_dice_pool_roller.sv
// Self-checking bench for dice_pool_roller with a behavioural roll model.
module tb_dice_pool_roller;
    import dice_pkg::*;

    localparam int NB    = 8;
    localparam int DB    = 5;
    localparam int DEPTH = 32;
    localparam int MD    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dice_pool_roller_if #(.NUM_BITS(NB), .DIE_BITS(DB), .DEPTH(DEPTH), .MAX_DICE(MD)) bus ();

    dice_pool_roller #(
        .NUM_BITS(NB), .DIE_BITS(DB), .DEPTH(DEPTH), .MAX_DICE(MD), .DIE_SIDES(20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    int m_table [DEPTH];
    int m_ptr;

    logic [DB-1:0]        e_rand;
    logic signed [NB-1:0] e_final;
    logic                 e_hit, e_crit, e_fumble;
    int                   e_lat;

    logic [DB-1:0]        o_rand;
    logic signed [NB-1:0] o_final;
    logic                 o_hit, o_crit, o_fumble, o_busy_after;
    int                   o_lat;

    // Roll by the game rules: pick n dice off the table, sum or keep best/worst.
    task automatic model_roll(input int mode, input int nd, input int md, input int tgt);
        int n, v, sum, kept, last, f;
        bit adv_dis, single;
        adv_dis = (mode == 1) || (mode == 2);
        if (adv_dis)      n = 2;
        else if (nd == 0) n = 1;
        else if (nd > MD) n = MD;
        else              n = nd;
        sum = 0; kept = 0; last = 0;
        for (int i = 0; i < n; i++) begin
            v = m_table[m_ptr];
            m_ptr = (m_ptr + 1) % DEPTH;
            sum += v;
            last = v;
            if (i == 0) kept = v;
            else if (mode == 1 && v > kept) kept = v;
            else if (mode == 2 && v < kept) kept = v;
        end
        f = (adv_dis ? kept : sum) + md;
        if (f > 127)  f = 127;
        if (f < -128) f = -128;
        e_final  = NB'(f);
        e_hit    = (f >= tgt);
        e_rand   = adv_dis ? DB'(kept) : DB'(last);
        single   = adv_dis || (n == 1);
        e_crit   = single && (e_rand == DB'(20));
        e_fumble = single && (e_rand == DB'(1));
        e_lat    = n + 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_entry(input int a, input int d);
        bus.write = 1'b1;
        bus.addr  = 5'(a);
        bus.data  = 5'(d);
        @(posedge clk); #1;
        bus.write = 1'b0;
        m_table[a] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_ptr = 0;
    endtask

    // Issue one request and wait (bounded) for done; o_lat = -1 on timeout.
    task automatic issue_roll(input int mode, input int nd, input int md, input int tgt);
        bus.mode     = 2'(mode);
        bus.num_dice = 3'(nd);
        bus.mod      = NB'(md);
        bus.target   = NB'(tgt);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        o_busy_after = bus.busy;
        o_lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                o_lat = c;
                break;
            end
        end
        o_rand   = bus.random_num;
        o_final  = bus.final_num;
        o_hit    = bus.hit;
        o_crit   = bus.crit;
        o_fumble = bus.fumble;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.rd_ptr !== 5'd0) $display("FAIL rst_ptr: got %0d want 0", bus.rd_ptr); else n_pass++;
        n_total++; if (bus.final_num !== 8'sd0) $display("FAIL rst_final: got %0d want 0", bus.final_num); else n_pass++;
        n_total++; if ({bus.random_num, bus.hit, bus.crit, bus.fumble} !== 8'd0)
            $display("FAIL rst_flags: got %h want 0", {bus.random_num, bus.hit, bus.crit, bus.fumble}); else n_pass++;
        n_total++; if (bus.dbg_state !== IDLE) $display("FAIL rst_state: got %0d want %0d", bus.dbg_state, IDLE); else n_pass++;
        reset = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_single_die();
        write_entry(0, 7); write_entry(1, 20); write_entry(2, 1); write_entry(3, 13); write_entry(4, 4);
        model_roll(0, 1, 5, 10);
        issue_roll(0, 1, 5, 10);
        n_total++; if (o_busy_after !== 1'b1) $display("FAIL single_busy: got %b want 1", o_busy_after); else n_pass++;
        n_total++; if (o_lat !== 2) $display("FAIL single_latency: got %0d want 2", o_lat); else n_pass++;
        n_total++; if (o_rand !== 5'd7) $display("FAIL single_rand: got %0d want 7", o_rand); else n_pass++;
        n_total++; if (o_final !== 8'sd12) $display("FAIL single_final: got %0d want 12", o_final); else n_pass++;
        n_total++; if ({o_hit, o_crit, o_fumble} !== 3'b100) $display("FAIL single_flags: got %b want 100", {o_hit, o_crit, o_fumble}); else n_pass++;
        n_total++; if (bus.rd_ptr !== 5'd1) $display("FAIL single_ptr: got %0d want 1", bus.rd_ptr); else n_pass++;
    endtask

    task automatic test_advantage();
        model_roll(1, 0, -3, 18);
        issue_roll(1, 0, -3, 18);
        n_total++; if (o_lat !== 3) $display("FAIL adv_latency: got %0d want 3", o_lat); else n_pass++;
        n_total++; if (o_rand !== 5'd20) $display("FAIL adv_rand: got %0d want 20", o_rand); else n_pass++;
        n_total++; if (o_final !== 8'sd17) $display("FAIL adv_final: got %0d want 17", o_final); else n_pass++;
        n_total++; if ({o_hit, o_crit, o_fumble} !== 3'b010) $display("FAIL adv_flags: got %b want 010", {o_hit, o_crit, o_fumble}); else n_pass++;
        n_total++; if (bus.rd_ptr !== 5'd3) $display("FAIL adv_ptr: got %0d want 3", bus.rd_ptr); else n_pass++;
    endtask

    task automatic test_disadvantage();
        do_reset();
        write_entry(0, 1); write_entry(1, 20);
        model_roll(2, 0, 0, 1);
        issue_roll(2, 0, 0, 1);
        n_total++; if (o_rand !== 5'd1) $display("FAIL dis_rand: got %0d want 1", o_rand); else n_pass++;
        n_total++; if (o_final !== 8'sd1) $display("FAIL dis_final: got %0d want 1", o_final); else n_pass++;
        n_total++; if ({o_hit, o_crit, o_fumble} !== 3'b101) $display("FAIL dis_flags: got %b want 101", {o_hit, o_crit, o_fumble}); else n_pass++;
        n_total++; if (bus.rd_ptr !== 5'd2) $display("FAIL dis_ptr: got %0d want 2", bus.rd_ptr); else n_pass++;
    endtask

    task automatic test_wrap();
        // Consume 29 entries to bring the pointer from 2 to 31.
        for (int i = 0; i < 8; i++) begin
            model_roll(0, (i < 7) ? 4 : 1, 0, 0);
            issue_roll(0, (i < 7) ? 4 : 1, 0, 0);
            n_total++; if (o_final !== e_final) $display("FAIL advance_final: got %0d want %0d", o_final, e_final); else n_pass++;
        end
        n_total++; if (bus.rd_ptr !== 5'd31) $display("FAIL wrap_pre_ptr: got %0d want 31", bus.rd_ptr); else n_pass++;
        write_entry(31, 5); write_entry(0, 6); write_entry(1, 7);
        model_roll(0, 3, 0, 0);
        issue_roll(0, 3, 0, 0);
        n_total++; if (o_lat !== 4) $display("FAIL wrap_latency: got %0d want 4", o_lat); else n_pass++;
        n_total++; if (o_final !== 8'sd18) $display("FAIL wrap_final: got %0d want 18", o_final); else n_pass++;
        n_total++; if ({o_rand, o_crit, o_fumble} !== {5'd7, 2'b00}) $display("FAIL wrap_rand: got %0d/%b want 7/00", o_rand, {o_crit, o_fumble}); else n_pass++;
        n_total++; if (bus.rd_ptr !== 5'd2) $display("FAIL wrap_ptr: got %0d want 2", bus.rd_ptr); else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < DEPTH; i++) write_entry(i, 31);
        model_roll(0, 7, 127, 0);
        issue_roll(0, 7, 127, 0);
        n_total++; if (o_lat !== 5) $display("FAIL clamp_latency: got %0d want 5", o_lat); else n_pass++;
        n_total++; if (o_final !== 8'sd127) $display("FAIL sat_high: got %0d want 127", o_final); else n_pass++;
        n_total++; if (bus.rd_ptr !== 5'(m_ptr)) $display("FAIL clamp_ptr: got %0d want %0d", bus.rd_ptr, m_ptr); else n_pass++;
        for (int i = 0; i < DEPTH; i++) write_entry(i, 1);
        model_roll(0, 1, -128, -128);
        issue_roll(0, 1, -128, -128);
        n_total++; if (o_final !== -8'sd127) $display("FAIL sat_low_final: got %0d want -127", o_final); else n_pass++;
        n_total++; if ({o_hit, o_fumble} !== 2'b11) $display("FAIL sat_low_flags: got %b want 11", {o_hit, o_fumble}); else n_pass++;
    endtask

    task automatic test_reset_mid_roll();
        int pulses;
        for (int i = 0; i < DEPTH; i++) write_entry(i, $urandom_range(1, 20));
        bus.mode = 2'd0; bus.num_dice = 3'd4; bus.mod = 8'sd3; bus.target = 8'sd0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_ptr = 0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.rd_ptr !== 5'd0) $display("FAIL midrst_ptr: got %0d want 0", bus.rd_ptr); else n_pass++;
        n_total++; if ({bus.final_num, bus.random_num} !== 13'd0) $display("FAIL midrst_results: got %0d/%0d want 0/0", bus.final_num, bus.random_num); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) pulses++;
            @(posedge clk); #1;
        end
        n_total++; if (pulses !== 0) $display("FAIL midrst_done: got %0d pulses want 0", pulses); else n_pass++;
        model_roll(0, 1, 0, 0);
        issue_roll(0, 1, 0, 0);
        n_total++; if (o_rand !== e_rand) $display("FAIL midrst_table: got %0d want %0d", o_rand, e_rand); else n_pass++;
    endtask

    task automatic test_write_start_conflict();
        int a, pulses;
        a = m_ptr;
        bus.write = 1'b1; bus.addr = 5'(a); bus.data = 5'd9;
        bus.mode = 2'd0; bus.num_dice = 3'd1; bus.mod = 8'sd0; bus.target = 8'sd0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.write = 1'b0; bus.start = 1'b0;
        m_table[a] = 9;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL conflict_busy: got %b want 0", bus.busy); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        n_total++; if (pulses !== 0 || bus.rd_ptr !== 5'(a)) $display("FAIL conflict_noroll: got %0d pulses ptr %0d want 0 ptr %0d", pulses, bus.rd_ptr, a); else n_pass++;
        model_roll(0, 1, 0, 0);
        issue_roll(0, 1, 0, 0);
        n_total++; if (o_rand !== 5'd9) $display("FAIL conflict_write: got %0d want 9", o_rand); else n_pass++;
    endtask

    task automatic test_write_while_busy();
        int wa, got;
        wa = (m_ptr + 6) % DEPTH;
        model_roll(0, 4, 0, 0);
        bus.mode = 2'd0; bus.num_dice = 3'd4; bus.mod = 8'sd0; bus.target = 8'sd0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.write = 1'b1; bus.addr = 5'(wa); bus.data = 5'((m_table[wa] % 20) + 1);
        @(posedge clk); #1;
        bus.write = 1'b0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done) begin got = 1; break; end
            @(posedge clk); #1;
        end
        n_total++; if (got !== 1 || bus.final_num !== e_final) $display("FAIL busy_roll: done %0d final %0d want 1 %0d", got, bus.final_num, e_final); else n_pass++;
        model_roll(0, 3, 0, 0);
        issue_roll(0, 3, 0, 0);
        n_total++; if (o_rand !== e_rand) $display("FAIL busy_write_dropped: got %0d want %0d", o_rand, e_rand); else n_pass++;
        n_total++; if (o_final !== e_final) $display("FAIL busy_write_sum: got %0d want %0d", o_final, e_final); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            model_roll(i, 2, 1, 10);
            issue_roll(i, 2, 1, 10);
            n_total++; if (o_busy_after !== 1'b1 || o_lat !== e_lat)
                $display("FAIL b2b_accept: busy %b lat %0d want 1 %0d", o_busy_after, o_lat, e_lat); else n_pass++;
            n_total++; if (o_final !== e_final) $display("FAIL b2b_final: got %0d want %0d", o_final, e_final); else n_pass++;
        end
    endtask

    task automatic test_random();
        int mode, nd, md, tgt;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) write_entry($urandom_range(0, DEPTH - 1), $urandom_range(1, 20));
            mode = $urandom_range(0, 3);
            nd   = $urandom_range(0, 7);
            md   = int'($urandom_range(0, 255)) - 128;
            tgt  = int'($urandom_range(0, 255)) - 128;
            model_roll(mode, nd, md, tgt);
            issue_roll(mode, nd, md, tgt);
            n_total++; if (o_lat !== e_lat) $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, o_lat, e_lat); else n_pass++;
            n_total++; if ({o_rand, o_final, o_hit, o_crit, o_fumble} !== {e_rand, e_final, e_hit, e_crit, e_fumble})
                $display("FAIL rnd_result[%0d] m%0d n%0d mod%0d t%0d: got r%0d f%0d h%b c%b u%b want r%0d f%0d h%b c%b u%b",
                         i, mode, nd, md, tgt, o_rand, o_final, o_hit, o_crit, o_fumble,
                         e_rand, e_final, e_hit, e_crit, e_fumble);
            else n_pass++;
            n_total++; if (bus.rd_ptr !== 5'(m_ptr)) $display("FAIL rnd_ptr[%0d]: got %0d want %0d", i, bus.rd_ptr, m_ptr); else n_pass++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0;
        bus.write = 1'b0; bus.addr = '0; bus.data = '0;
        bus.start = 1'b0; bus.mode = '0; bus.num_dice = '0;
        bus.mod = '0; bus.target = '0;
        m_ptr = 0;
        for (int i = 0; i < DEPTH; i++) m_table[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        for (int i = 0; i < DEPTH; i++) write_entry(i, $urandom_range(1, 20));
        test_single_die();
        test_advantage();
        test_disadvantage();
        test_wrap();
        test_saturation();
        test_reset_mid_roll();
        test_write_start_conflict();
        test_write_while_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
